// File: rtl/triangle_pkg.sv
// +----------------------------------------------------------------------------+
// | triangle_pkg : shared types and step constants for triangle_monitor        |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package triangle_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      RISING  = 2'd2,
      FALLING = 2'd3
   } monitor_state_t;

   typedef enum logic {
      COUNTING_DOWN = 1'b0,
      COUNTING_UP   = 1'b1
   } count_dir_t;

   // Modular step values for an n-bit ramp: +1 and -1 (all ones).
   function automatic logic [31:0] step_up_val(input int unsigned n);
      return (n == 0) ? 32'd0 : 32'd1;
   endfunction

   function automatic logic [31:0] step_dn_val(input int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/triangle_monitor_step_classifier.sv
// +----------------------------------------------------------------------------+
// | step_classifier : classifies prev->sample as +1, -1 or anything else        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module step_classifier
   import triangle_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] prev_i,
   input  logic [N-1:0] sample_i,
   output logic         up_o,
   output logic         dn_o,
   output logic         bad_o
);

   localparam logic [N-1:0] STEP_UP = N'(step_up_val(N));
   localparam logic [N-1:0] STEP_DN = N'(step_dn_val(N));

   logic [N-1:0] delta;

   // Modular difference makes the 2^N-1 -> 0 wrap an ordinary up step.
   assign delta = sample_i - prev_i;
   assign up_o  = (delta == STEP_UP);
   assign dn_o  = (delta == STEP_DN);
   assign bad_o = ~(up_o | dn_o);

endmodule

`default_nettype wire

// File: rtl/triangle_monitor.sv
// +----------------------------------------------------------------------------+
// | triangle_monitor : ramp direction / turn / step checker for triangle waves |
// | Optional macro   : TRIANGLE_MONITOR_RANGE_CHECK_EN enables range_err        |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module triangle_monitor
   import triangle_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [N-1:0]     in,
   output logic             peak,
   output logic             trough,
   output logic [N-1:0]     extreme,
   output logic [CNT_W-1:0] half_period,
   output logic             step_err,
   output logic             locked,
   output logic             dir,
   output logic             range_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   monitor_state_t   state_q;
   count_dir_t       dir_q;
   logic [N-1:0]     prev_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             peak_q;
   logic             trough_q;
   logic [N-1:0]     extreme_q;
   logic [CNT_W-1:0] half_period_q;
   logic             step_err_q;
   logic             locked_q;
   logic             up;
   logic             dn;
   logic             bad;

   step_classifier #(.N(N)) u_step_classifier (
      .prev_i   (prev_q),
      .sample_i (in),
      .up_o     (up),
      .dn_o     (dn),
      .bad_o    (bad)
   );

   assign count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         dir_q         <= COUNTING_DOWN;
         prev_q        <= '0;
         count_q       <= '0;
         peak_q        <= 1'b0;
         trough_q      <= 1'b0;
         extreme_q     <= '0;
         half_period_q <= '0;
         step_err_q    <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         peak_q     <= 1'b0;
         trough_q   <= 1'b0;
         step_err_q <= 1'b0;
         if (ena) begin
            prev_q <= in;
            case (state_q)
               IDLE: begin
                  state_q <= ACQUIRE;
                  dir_q   <= COUNTING_DOWN;
               end
               ACQUIRE: begin
                  if (up) begin
                     state_q <= RISING;
                     dir_q   <= COUNTING_UP;
                     count_q <= CNT_ONE;
                  end else if (dn) begin
                     state_q <= FALLING;
                     dir_q   <= COUNTING_DOWN;
                     count_q <= CNT_ONE;
                  end
               end
               RISING: begin
                  if (bad) begin
                     state_q    <= ACQUIRE;
                     dir_q      <= COUNTING_DOWN;
                     step_err_q <= 1'b1;
                     locked_q   <= 1'b0;
                     count_q    <= '0;
                  end else if (up) begin
                     count_q <= count_d;
                  end else begin
                     state_q       <= FALLING;
                     dir_q         <= COUNTING_DOWN;
                     peak_q        <= 1'b1;
                     extreme_q     <= prev_q;
                     half_period_q <= count_q;
                     count_q       <= CNT_ONE;
                     locked_q      <= 1'b1;
                  end
               end
               FALLING: begin
                  if (bad) begin
                     state_q    <= ACQUIRE;
                     dir_q      <= COUNTING_DOWN;
                     step_err_q <= 1'b1;
                     locked_q   <= 1'b0;
                     count_q    <= '0;
                  end else if (dn) begin
                     count_q <= count_d;
                  end else begin
                     state_q       <= RISING;
                     dir_q         <= COUNTING_UP;
                     trough_q      <= 1'b1;
                     extreme_q     <= prev_q;
                     half_period_q <= count_q;
                     count_q       <= CNT_ONE;
                     locked_q      <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  dir_q   <= COUNTING_DOWN;
               end
            endcase
         end
      end
   end

`ifdef TRIANGLE_MONITOR_RANGE_CHECK_EN
   logic range_err_q;

   // A healthy full-scale triangle turns only at the rails.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         range_err_q <= 1'b0;
      end else begin
         range_err_q <= ena &&
                        ((state_q == RISING  && !bad && !up && (prev_q != '1)) ||
                         (state_q == FALLING && !bad && !dn && (prev_q != '0)));
      end
   end

   assign range_err = range_err_q;
`else
   assign range_err = 1'b0;
`endif

   assign peak        = peak_q;
   assign trough      = trough_q;
   assign extreme     = extreme_q;
   assign half_period = half_period_q;
   assign step_err    = step_err_q;
   assign locked      = locked_q;
   assign dir         = (dir_q == COUNTING_UP);

endmodule

`default_nettype wire

// File: tb/tb_triangle_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_triangle_monitor : directed + random bench with a run-length model      |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_triangle_monitor;

   localparam int N     = 4;
   localparam int CNT_W = 8;
   localparam int MODV  = 16;
   localparam int SAT   = 255;
`ifdef TRIANGLE_MONITOR_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             ena;
   logic [N-1:0]     in;
   logic             peak;
   logic             trough;
   logic [N-1:0]     extreme;
   logic [CNT_W-1:0] half_period;
   logic             step_err;
   logic             locked;
   logic             dir;
   logic             range_err;

   triangle_monitor #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .in          (in),
      .peak        (peak),
      .trough      (trough),
      .extreme     (extreme),
      .half_period (half_period),
      .step_err    (step_err),
      .locked      (locked),
      .dir         (dir),
      .range_err   (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phase 0 = fresh, 1 = hunting for a unit step, 2 = inside a run.
   int m_phase, m_run, m_len, m_prev, m_locked;
   int e_peak, e_trough, e_ext, e_hp, e_step, e_range;

   task automatic model_reset();
      m_phase = 0; m_run = 0; m_len = 0; m_prev = 0; m_locked = 0;
      e_peak = 0; e_trough = 0; e_ext = 0; e_hp = 0; e_step = 0; e_range = 0;
   endtask

   task automatic model_sample(input bit e, input int v);
      int d, s;
      e_peak = 0; e_trough = 0; e_step = 0; e_range = 0;
      if (e) begin
         d = (v - m_prev + MODV) % MODV;
         s = (d == 1) ? 1 : ((d == MODV - 1) ? -1 : 0);
         if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 1) begin
            if (s != 0) begin
               m_phase = 2; m_run = s; m_len = 1;
            end
         end else if (s == m_run) begin
            m_len = (m_len < SAT) ? m_len + 1 : SAT;
         end else if (s == -m_run) begin
            e_peak   = (m_run > 0) ? 1 : 0;
            e_trough = (m_run < 0) ? 1 : 0;
            e_ext    = m_prev;
            e_hp     = m_len;
            if (RANGE_EN)
               e_range = (m_run > 0) ? int'(m_prev != MODV - 1) : int'(m_prev != 0);
            m_run = s; m_len = 1; m_locked = 1;
         end else begin
            e_step = 1; m_phase = 1; m_len = 0; m_locked = 0;
         end
         m_prev = v;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".peak"},        32'(peak),        32'(e_peak));
      chk({tag, ".trough"},      32'(trough),      32'(e_trough));
      chk({tag, ".extreme"},     32'(extreme),     32'(e_ext));
      chk({tag, ".half_period"}, 32'(half_period), 32'(e_hp));
      chk({tag, ".step_err"},    32'(step_err),    32'(e_step));
      chk({tag, ".locked"},      32'(locked),      32'(m_locked));
      chk({tag, ".dir"},         32'(dir),         32'((m_phase == 2 && m_run == 1) ? 1 : 0));
      chk({tag, ".range_err"},   32'(range_err),   32'(e_range));
   endtask

   // Present one sample, clock it in and compare everything against the model.
   task automatic step(input string tag, input bit e, input int v);
      ena = e;
      in  = N'(v);
      @(posedge clk);
      #1;
      if (!rst) model_reset();
      else      model_sample(e, v);
      check_all(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cur, dv, nxt, r;
      bit e;

      rst = 1'b0; ena = 1'b0; in = '0;
      model_reset();

      // reset held with ena toggling
      for (int i = 0; i < 4; i++) step("rst_hold", i[0], int'($urandom_range(0, 15)));
      #2 rst = 1'b1;
      step("first", 1'b1, 3);
      chk("first.dir", 32'(dir), 32'd0);
      chk("first.locked", 32'(locked), 32'd0);

      // full rising ramp then turn
      step("ramp", 1'b1, 0);
      for (int v = 1; v <= 15; v++) step("rise", 1'b1, v);
      step("peak", 1'b1, 14);
      chk("t2.peak", 32'(peak), 32'd1);
      chk("t2.extreme", 32'(extreme), 32'd15);
      chk("t2.hp", 32'(half_period), 32'd15);
      chk("t2.locked", 32'(locked), 32'd1);
      chk("t2.dir", 32'(dir), 32'd0);

      for (int v = 13; v >= 0; v--) step("fall", 1'b1, v);
      step("trough", 1'b1, 1);
      chk("t3.trough", 32'(trough), 32'd1);
      chk("t3.extreme", 32'(extreme), 32'd0);
      chk("t3.hp", 32'(half_period), 32'd15);
      chk("t3.dir", 32'(dir), 32'd1);

      // stall mid-ramp with garbage on in
      step("pre_stall", 1'b1, 2);
      step("pre_stall", 1'b1, 3);
      for (int i = 0; i < 5; i++) step("stall", 1'b0, int'($urandom_range(0, 15)));
      step("resume", 1'b1, 4);
      chk("t4.step_err", 32'(step_err), 32'd0);
      chk("t4.dir", 32'(dir), 32'd1);

      // step error while locked and rising
      step("lk", 1'b1, 3);
      step("lk", 1'b1, 2);
      step("lk", 1'b1, 3);
      chk("t5.locked_before", 32'(locked), 32'd1);
      for (int v = 4; v <= 6; v++) step("lk", 1'b1, v);
      step("jump", 1'b1, 8);
      chk("t5.step_err", 32'(step_err), 32'd1);
      chk("t5.locked", 32'(locked), 32'd0);
      step("recover", 1'b1, 9);
      step("recover", 1'b1, 10);
      chk("t5.dir", 32'(dir), 32'd1);
      chk("t5.no_err", 32'(step_err), 32'd0);

      // short ramp turning below full scale
      step("short", 1'b1, 7);
      for (int v = 0; v <= 12; v++) step("short", 1'b1, v);
      step("short_pk", 1'b1, 11);
      chk("t6.peak", 32'(peak), 32'd1);
      chk("t6.extreme", 32'(extreme), 32'd12);
      chk("t6.range_err", 32'(range_err), RANGE_EN ? 32'd1 : 32'd0);

      // long wrapping run saturates the counter
      for (int i = 0; i <= 300; i++) step("sat", 1'b1, i % MODV);
      step("sat_pk", 1'b1, (300 % MODV) - 1);
      chk("sat.peak", 32'(peak), 32'd1);
      chk("sat.hp", 32'(half_period), 32'd255);

      // randomized triangle-ish stream
      cur = 5; dv = 1;
      for (int i = 0; i < 400; i++) begin
         e = ($urandom_range(0, 7) != 0);
         r = int'($urandom_range(0, 19));
         if (r == 0) begin
            nxt = int'($urandom_range(0, 15));
         end else begin
            if (r < 3) dv = -dv;
            nxt = (cur + dv + MODV) % MODV;
         end
         if (e) begin
            step("rand", 1'b1, nxt);
            cur = nxt;
         end else begin
            step("rand", 1'b0, int'($urandom_range(0, 15)));
         end
      end

      // asynchronous reset mid-ramp
      for (int v = 4; v <= 7; v++) step("pre_rst", 1'b1, v);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      step("rst_low", 1'b0, 0);
      #2 rst = 1'b1;
      step("post8", 1'b1, 8);
      chk("t7.dir8", 32'(dir), 32'd0);
      step("post9", 1'b1, 9);
      chk("t7.dir9", 32'(dir), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
